mmio_access_ctrl: RTL and testbench
===================================

Name: mmio_access_ctrl

Overview:
- Sequences load/store instructions whose address falls in the MMIO window. These are the accesses the data-memory path suppresses.
- Sits beside the MEM stage. It accepts one access, stalls the pipeline, and runs a valid/ready request plus read-response handshake on the peripheral bus.
- It returns aligned load data, or an error on timeout, then releases the stall.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles spent in REQ+WAIT before the access is aborted with error; legal range 2..65535.
- BIG_ENDIAN, 0: 1 = byte-swap word write data and word read data.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage has a condition-passed MMIO load/store.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word.
- req_addr  in  32  effective address.
- req_wdata  in  32  store data (register value, unformatted).
- stall  out  1  hold IF..MEM stages.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  formatted load data, valid with rsp_valid.
- rsp_err  out  1  access timed out, valid with rsp_valid.
- bus_valid  out  1  request valid.
- bus_write  out  1  request is write.
- bus_addr  out  32  word-aligned address (addr[31:2], 2'b00).
- bus_wdata  out  32  formatted write data.
- bus_be  out  4  byte enables.
- bus_ready  in  1  bus accepts request when bus_valid && bus_ready.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n=0) values:
  - state = IDLE.
  - All outputs 0: stall, rsp_valid, rsp_rdata, rsp_err, bus_valid, bus_write, bus_addr, bus_wdata, bus_be.
  - Timeout counter 0.
  - Reset mid-access abandons it; bus_valid drops immediately; late bus_ready/bus_rvalid are ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid, combinational, same cycle.
  - On req_valid, latch write, byte, addr and formatted data/be into registers, clear counter, go to REQ.
- REQ:
  - bus_valid=1 and bus_* driven from the latched registers, stable until handshake.
  - stall=1.
  - On bus_ready: a write goes to DONE; a read goes to WAIT.
- WAIT:
  - stall=1, bus_valid=0.
  - On bus_rvalid, capture the formatted read data and go to DONE.
  - bus_rvalid in the same cycle as REQ's bus_ready is not accepted; data is taken only in WAIT.
- Timeout:
  - Counter increments each cycle in REQ or WAIT.
  - When counter == TIMEOUT_CYCLES-1 and the exiting handshake is absent, go to DONE with err=1 and rdata=0.
  - A handshake in the same cycle as expiry wins: normal completion, err=0.
- DONE:
  - stall=0, rsp_valid=1, rsp_err/rsp_rdata held.
  - Always go to IDLE next cycle.
  - req_valid in DONE is ignored; the completing instruction advances at this edge.
  - rsp_rdata/rsp_err hold until the next DONE; rsp_valid is 0 outside DONE.
- Write formatting:
  - Byte: wdata = {4{req_wdata[7:0]}}, be = one-hot at addr[1:0] (00→0001, 11→1000).
  - Word: be = 1111; data as-is, or byte-reversed if BIG_ENDIAN.
- Read formatting:
  - Byte: zero-extended lane bus_rdata[8*addr[1:0]+:8].
  - Word: as-is, or byte-reversed if BIG_ENDIAN.
  - Unaligned word address is not rotated; bus_addr is aligned.
- Latency:
  - Minimum write: IDLE→REQ (ready at once)→DONE = rsp_valid 2 cycles after req_valid.
  - Minimum read: 3 cycles.

Test Plan:
- Word store addr 0xFFFF0004, wdata 0x11223344, bus_ready=1 immediately → one bus_valid cycle with be=1111, wdata 0x11223344, addr 0xFFFF0004. rsp_valid at cycle +2, rsp_err=0, stall high for cycles 0..1.
- Byte load addr 0xFFFF0013, bus_ready after 3 cycles, bus_rvalid 2 cycles later with 0xAABBCCDD → bus_addr 0xFFFF0010, rsp_rdata 0x000000AA, stall released only in DONE.
- Byte store addr …02, data 0x0000005A → bus_be 0100, bus_wdata 0x5A5A5A5A.
- bus_ready never asserted, TIMEOUT_CYCLES=4 → bus_valid high 4 cycles, then rsp_valid with rsp_err=1, rdata 0; next req is accepted normally.
- BIG_ENDIAN=1 word load returning 0x01020304 → rsp_rdata 0x04030201.
- rst_n dropped while in WAIT → outputs 0 asynchronously. After release, a late bus_rvalid produces no rsp_valid.

Source files
------------

// File: rtl/mmio_access_ctrl.sv
// Sequences one MMIO load/store at a time onto a valid/ready peripheral bus,
// stalling the pipeline until the bus responds or the access times out.
module mmio_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          BIG_ENDIAN     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        is_byte;
    logic [1:0]  lane;
    logic        expired;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_rdata;

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // >= rather than == so a read whose request handshake lands on the last
    // budgeted cycle still expires in WAIT instead of running until wrap.
    assign expired = (cnt >= 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        fmt_wdata = req_wdata;
        fmt_be    = 4'b1111;
        if (req_byte) begin
            fmt_wdata = {4{req_wdata[7:0]}};
            fmt_be    = 4'b0001 << req_addr[1:0];
        end else if (BIG_ENDIAN) begin
            fmt_wdata = swap32(req_wdata);
        end
    end

    always_comb begin
        fmt_rdata = bus_rdata;
        if (is_byte) begin
            fmt_rdata = {24'h000000, bus_rdata[{lane, 3'b000} +: 8]};
        end else if (BIG_ENDIAN) begin
            fmt_rdata = swap32(bus_rdata);
        end
    end

    assign stall     = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
    assign bus_valid = (state == REQ);
    assign rsp_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_byte   <= 1'b0;
            lane      <= '0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bus_write <= req_write;
                        is_byte   <= req_byte;
                        lane      <= req_addr[1:0];
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_wdata <= fmt_wdata;
                        bus_be    <= fmt_be;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 16'd1;
                    if (bus_ready) begin
                        if (bus_write) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (bus_rvalid) begin
                        rsp_rdata <= fmt_rdata;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end else if (expired) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_access_ctrl.sv
// Scoreboard bench for mmio_access_ctrl: little- and big-endian instances share
// one stimulus stream; a monitor compares bus requests and responses to a model.
module tb_mmio_access_ctrl;

    localparam int unsigned T = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        stall0, rsp_valid0, rsp_err0, bus_valid0, bus_write0;
    logic [31:0] rsp_rdata0, bus_addr0, bus_wdata0;
    logic [3:0]  bus_be0;
    logic        stall1, rsp_valid1, rsp_err1, bus_valid1, bus_write1;
    logic [31:0] rsp_rdata1, bus_addr1, bus_wdata1;
    logic [3:0]  bus_be1;

    always #5 clk = ~clk;

    mmio_access_ctrl #(.TIMEOUT_CYCLES(T), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .bus_valid(bus_valid0), .bus_write(bus_write0), .bus_addr(bus_addr0),
        .bus_wdata(bus_wdata0), .bus_be(bus_be0), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    mmio_access_ctrl #(.TIMEOUT_CYCLES(T), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall1), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .bus_valid(bus_valid1), .bus_write(bus_write1), .bus_addr(bus_addr1),
        .bus_wdata(bus_wdata1), .bus_be(bus_be1), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wd_le;
        logic [31:0] wd_be;
        logic [3:0]  be;
    } breq_t;

    typedef struct {
        logic [31:0] rd_le;
        logic [31:0] rd_be;
        logic        err;
        int          cyc;
    } rsp_t;

    breq_t bq[$];
    rsp_t  rq[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] swap(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 4; i++) y[8*i +: 8] = x[8*(3-i) +: 8];
        return y;
    endfunction

    // Monitor: samples 2 time units after the falling edge, once inputs are settled.
    always @(negedge clk) begin
        breq_t b;
        rsp_t  r;
        #2;
        if (rst_n && bus_valid0 && bus_ready) begin
            if (bq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_bus_req: got addr %08h expected none", bus_addr0);
            end else begin
                b = bq.pop_front();
                chk("bus_write", bus_write0, b.w);
                chk("bus_addr_le", bus_addr0, b.addr);
                chk("bus_addr_be", bus_addr1, b.addr);
                chk("bus_wdata_le", bus_wdata0, b.wd_le);
                chk("bus_wdata_be", bus_wdata1, b.wd_be);
                chk("bus_be_le", bus_be0, b.be);
                chk("bus_be_be", bus_be1, b.be);
                chk("bus_valid_be", bus_valid1, 1'b1);
            end
        end
        if (rsp_valid0 || rsp_valid1) begin
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: got rsp_valid %b/%b expected 0/0", rsp_valid0, rsp_valid1);
            end else begin
                r = rq.pop_front();
                chk("rsp_valid_le", rsp_valid0, 1'b1);
                chk("rsp_valid_be", rsp_valid1, 1'b1);
                chk("rsp_err_le", rsp_err0, r.err);
                chk("rsp_err_be", rsp_err1, r.err);
                chk("rsp_rdata_le", rsp_rdata0, r.rd_le);
                chk("rsp_rdata_be", rsp_rdata1, r.rd_be);
                chk("rsp_latency", cyc, r.cyc);
            end
        end
    end

    // rd: cycles of REQ before bus_ready; wd: cycles of WAIT before bus_rvalid.
    task automatic run_txn(input bit wr, input bit byt, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdat,
                           input int rd, input int wd, input bit early, input bit ghost);
        breq_t b;
        rsp_t  r;
        int    c0, k, j;
        bit    in_wait, done;
        logic [1:0] lane;
        lane = addr[1:0];
        @(negedge clk);
        c0 = cyc;
        req_valid = 1'b1; req_write = wr; req_byte = byt; req_addr = addr; req_wdata = wdata;
        if (rd < int'(T)) begin
            b.w     = wr;
            b.addr  = {addr[31:2], 2'b00};
            b.wd_le = byt ? {4{wdata[7:0]}} : wdata;
            b.wd_be = byt ? {4{wdata[7:0]}} : swap(wdata);
            b.be    = byt ? (4'b0001 << lane) : 4'b1111;
            bq.push_back(b);
        end
        if (rd >= int'(T) || (!wr && rd + 1 + wd >= int'(T))) begin
            r = '{rd_le: 32'h0, rd_be: 32'h0, err: 1'b1, cyc: c0 + int'(T) + 1};
        end else if (wr) begin
            r = '{rd_le: 32'h0, rd_be: 32'h0, err: 1'b0, cyc: c0 + rd + 2};
        end else if (byt) begin
            r = '{rd_le: (rdat >> (8 * lane)) & 32'hFF, rd_be: (rdat >> (8 * lane)) & 32'hFF,
                  err: 1'b0, cyc: c0 + rd + wd + 3};
        end else begin
            r = '{rd_le: rdat, rd_be: swap(rdat), err: 1'b0, cyc: c0 + rd + wd + 3};
        end
        rq.push_back(r);
        #1;
        chk("stall_same_cycle", stall0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_byte = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        k = 0; j = 0; in_wait = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rsp_valid0) begin
                done = 1'b1;
            end else begin
                if (!in_wait) begin
                    bus_ready  = (k == rd);
                    bus_rvalid = (k == rd) && early;
                    bus_rdata  = ~rdat;
                end else begin
                    bus_ready  = 1'b0;
                    bus_rvalid = (j == wd);
                    bus_rdata  = (j == wd) ? rdat : $urandom;
                end
                #1;
                chk("stall_busy", stall0, 1'b1);
                chk("bus_valid_phase", bus_valid0, !in_wait);
                @(negedge clk);
                if (!in_wait) begin
                    if (k == rd && !wr) in_wait = 1'b1;
                    k++;
                end else begin
                    j++;
                end
            end
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
        end
        chk("stall_done", stall0, 1'b0);
        if (ghost) begin
            req_valid = 1'b1; req_addr = $urandom; bus_rvalid = 1'b1; bus_rdata = $urandom;
        end
        @(negedge clk);
        req_valid = 1'b0; bus_rvalid = 1'b0;
        #1;
        chk("idle_after_done", bus_valid0, 1'b0);
        chk("idle_stall", stall0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, stall0, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid0, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata0, 32'h0);
        chk({tag, "_rsp_err"}, rsp_err0, 1'b0);
        chk({tag, "_bus_valid"}, bus_valid0, 1'b0);
        chk({tag, "_bus_write"}, bus_write0, 1'b0);
        chk({tag, "_bus_addr"}, bus_addr0, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata0, 32'h0);
        chk({tag, "_bus_be"}, bus_be0, 4'h0);
        chk({tag, "_bus_valid_be"}, bus_valid1, 1'b0);
        chk({tag, "_rsp_rdata_be"}, rsp_rdata1, 32'h0);
    endtask

    task automatic reset_in_wait();
        breq_t b;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'hFFFF0020;
        b = '{w: 1'b0, addr: 32'hFFFF0020, wd_le: 32'h0, wd_be: 32'h0, be: 4'hF};
        b.wd_le = req_wdata; b.wd_be = swap(req_wdata);
        bq.push_back(b);
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        #1;
        chk("wait_bus_valid", bus_valid0, 1'b0);
        chk("wait_stall", stall0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_rvalid_ignored", rsp_valid0, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr, byt;
        int rd, wd;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(1, 0, 32'hFFFF0004, 32'h11223344, 32'h0, 0, 0, 0, 0);
        run_txn(0, 1, 32'hFFFF0013, 32'h0, 32'hAABBCCDD, 3, 1, 1, 0);
        run_txn(1, 1, 32'hFFFF0002, 32'h0000005A, 32'h0, 1, 0, 0, 0);
        run_txn(1, 0, 32'hFFFF0100, 32'hCAFEF00D, 32'h0, T + 2, 0, 0, 0);
        run_txn(0, 0, 32'hFFFF0008, 32'h0, 32'h01020304, 0, 0, 0, 1);
        run_txn(1, 0, 32'hFFFF000C, 32'h89ABCDEF, 32'h0, T - 1, 0, 0, 0);
        run_txn(0, 0, 32'hFFFF0010, 32'h0, 32'h55667788, 0, T - 2, 0, 0);
        run_txn(0, 1, 32'hFFFF0011, 32'h0, 32'h55667788, 0, T - 1, 0, 0);
        reset_in_wait();
        run_txn(1, 0, 32'hFFFF0040, 32'h0BADF00D, 32'h0, 0, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            wr  = 1'($urandom);
            byt = 1'($urandom);
            rd  = $urandom_range(0, T + 1);
            wd  = $urandom_range(0, T - 1);
            if (!wr && rd == int'(T) - 1) rd = int'(T) - 2;
            run_txn(wr, byt, 32'hFFFF0000 | 32'($urandom_range(0, 255)), $urandom, $urandom,
                    rd, wd, 1'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("bus_queue_empty", bq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
